// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC WIDTH-bit accumulators sharing one C/Z/N/V flag register.
// Define ACC_SAT_EN for signed saturation on ADD/ADC/SUB; otherwise results wrap modulo 2^WIDTH.
module accumulator_bank #(
   parameter int WIDTH = 8,
   parameter int NUM_ACC = 4,
   localparam int SEL_W = $clog2(NUM_ACC)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [SEL_W-1:0] sel,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc_out,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);
   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ADC  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;
`ifdef ACC_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [WIDTH-1:0] acc_bank [NUM_ACC];
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             add_v;
   logic             sub_v;
   logic             is_arith;
   logic             arith_v;
   logic             wr_en;
   logic             c_d, z_d, n_d, v_d;
   logic             c_q, z_q, n_q, v_q;

   assign cur     = acc_bank[sel];
   assign acc_out = cur;

   // One adder serves ADD and ADC; the carry-in is the flag value before the edge.
   assign sum   = {1'b0, cur} + {1'b0, operand} + {{WIDTH{1'b0}}, (op == OP_ADC) & c_q};
   assign diff  = {1'b0, cur} - {1'b0, operand};
   assign add_v = (cur[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
   assign sub_v = (cur[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] == operand[WIDTH-1]);

   always_comb begin
      acc_d    = cur;
      c_d      = c_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      wr_en    = 1'b0;
      is_arith = 1'b0;
      arith_v  = 1'b0;
      if (en) begin
         case (op)
            OP_HOLD: ;
            OP_LOAD: begin
               acc_d = operand;
               v_d   = 1'b0;
               wr_en = 1'b1;
            end
            OP_ADD, OP_ADC: begin
               acc_d    = sum[WIDTH-1:0];
               c_d      = sum[WIDTH];
               arith_v  = add_v;
               is_arith = 1'b1;
               wr_en    = 1'b1;
            end
            OP_SUB: begin
               acc_d    = diff[WIDTH-1:0];
               c_d      = diff[WIDTH];
               arith_v  = sub_v;
               is_arith = 1'b1;
               wr_en    = 1'b1;
            end
            OP_SHL: begin
               acc_d = {cur[WIDTH-2:0], 1'b0};
               c_d   = cur[WIDTH-1];
               v_d   = cur[WIDTH-1] ^ cur[WIDTH-2];
               wr_en = 1'b1;
            end
            OP_SHR: begin
               acc_d = {1'b0, cur[WIDTH-1:1]};
               c_d   = cur[0];
               v_d   = 1'b0;
               wr_en = 1'b1;
            end
            OP_CLR: begin
               acc_d = '0;
               c_d   = 1'b0;
               v_d   = 1'b0;
               wr_en = 1'b1;
            end
            default: ;
         endcase
         if (is_arith) begin
            v_d = arith_v;
`ifdef ACC_SAT_EN
            // On overflow the true result has the sign of the accumulator operand.
            if (arith_v) acc_d = cur[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
         end
         if (wr_en) begin
            z_d = (acc_d == '0);
            n_d = acc_d[WIDTH-1];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      logic [WIDTH-1:0] acc_q;
      always_ff @(posedge clock or posedge reset) begin
         if (reset)                                   acc_q <= '0;
         else if (wr_en && (sel == SEL_W'(gi)))       acc_q <= acc_d;
      end
      assign acc_bank[gi] = acc_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         c_q <= 1'b0;
         z_q <= 1'b0;
         n_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         c_q <= c_d;
         z_q <= z_d;
         n_q <= n_d;
         v_q <= v_d;
      end
   end

   assign flag_c = c_q;
   assign flag_z = z_q;
   assign flag_n = n_q;
   assign flag_v = v_q;
endmodule
